pc_sequencer: RTL

- Parametrised next-generation program counter for the CSE141L core. Supplies the instruction-memory line number each cycle.
- Adds to basic clear/hold/increment/relative-branch behaviour:
  - multi-program start table,
  - absolute jumps,
  - a hardware call/return stack,
  - a halt/done state machine.
- Sits between the control decoder/ALU flag logic and instruction ROM addressing.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/ret_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// The state encoding, default sizes and the program entry-point lookup all live here.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } pc_state_e;

    localparam int PC_W_DEF        = 11;
    localparam int TGT_W_DEF       = 8;
    localparam int NPROG_DEF       = 4;
    localparam int PROG_STRIDE_DEF = 256;
    localparam int STACK_DEPTH_DEF = 4;

    // Out-of-range selects fall back to program 0; the caller truncates to PC width.
    function automatic int unsigned prog_base(input int unsigned sel,
                                              input int unsigned nprog,
                                              input int unsigned stride);
        if (sel >= nprog) begin
            return 0;
        end
        return sel * stride;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop/clear take effect at the next posedge, and top/empty/full are live views of the stored state.
// Pushes while full and pops while empty are ignored; clear takes priority over push and pop.
module ret_stack #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] top_dat,
    output logic         empty,
    output logic         full
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign top_dat = mem_q[IDX_W'(count_q - CNT_W'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only ever read below the count.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem_q[IDX_W'(count_q)] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with program start table, absolute jumps, call/return stack and halt/done FSM.
// ProgCtr and the status outputs are registered and change one cycle after the inputs that cause them; there is no flow control.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int TGT_W       = TGT_W_DEF,
    parameter int NPROG       = NPROG_DEF,
    parameter int PROG_STRIDE = PROG_STRIDE_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int PSEL_W      = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Start,
    input  logic [PSEL_W-1:0] ProgSel,
    input  logic              BranchEn,
    input  logic              ALU_flag,
    input  logic [TGT_W-1:0]  Target,
    input  logic              JumpAbs,
    input  logic [PC_W-1:0]   AbsTarget,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Halt,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic              StackErr
);
    pc_state_e       state_q;
    logic [PC_W-1:0] pc_q;
    logic            running_q;
    logic            done_q;
    logic            stack_err_q;

    logic [PC_W-1:0] base_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_ext;
    logic [PC_W-1:0] pc_run_d;
    logic            run_err_d;
    logic            run_act;
    logic            stk_push;
    logic            stk_pop;
    logic            stk_clr;
    logic [PC_W-1:0] stk_top;
    logic            stk_empty;
    logic            stk_full;

    assign base_d  = PC_W'(prog_base(32'(ProgSel), NPROG, PROG_STRIDE));
    assign pc_inc  = pc_q + PC_W'(1);
    assign tgt_ext = PC_W'($signed(Target));

    // Stack only moves on a RUN cycle that is not pre-empted by restart or halt.
    assign run_act = (state_q == RUN) && !Start && !Halt;
    assign stk_clr = Start || (state_q == ARMED);

    always_comb begin
        pc_run_d  = pc_inc;
        run_err_d = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        if (Call && Ret) begin
            run_err_d = 1'b1;
        end else if (Ret) begin
            if (!stk_empty) begin
                pc_run_d = stk_top;
                stk_pop  = run_act;
            end else begin
                run_err_d = 1'b1;
            end
        end else if (Call) begin
            pc_run_d = AbsTarget;
            if (!stk_full) begin
                stk_push = run_act;
            end else begin
                run_err_d = 1'b1;
            end
        end else if (JumpAbs) begin
            pc_run_d = AbsTarget;
        end else if (BranchEn && ALU_flag) begin
            pc_run_d = pc_q + tgt_ext;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= ARMED;
                        pc_q    <= base_d;
                    end
                end
                ARMED: begin
                    stack_err_q <= 1'b0;
                    if (Start) begin
                        pc_q <= base_d;
                    end else begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (Start) begin
                        state_q   <= ARMED;
                        pc_q      <= base_d;
                        running_q <= 1'b0;
                    end else if (Halt) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_run_d;
                        if (run_err_d) begin
                            stack_err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state_q <= ARMED;
                        pc_q    <= base_d;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk      (Clk),
        .rst_n    (ResetN),
        .clear    (stk_clr),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dat (pc_inc),
        .top_dat  (stk_top),
        .empty    (stk_empty),
        .full     (stk_full)
    );

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign StackErr = stack_err_q;

endmodule
